// File: rtl/object_readout_ctrl_pkg.sv
// Shared defaults for the connected-components readout scheduler.
package object_readout_ctrl_pkg;

    localparam int DEF_LBL_WIDTH    = 4;
    localparam int DEF_LOC_SIZE     = 8;
    localparam int DEF_MAX_LABEL    = 1 << DEF_LBL_WIDTH;
    localparam int DEF_DRAIN_CYCLES = 4;

    // Drain counter holds DRAIN_CYCLES-1, so 4 bits cover the 1..15 range.
    typedef logic [3:0] drain_cnt_t;

endpackage

// File: rtl/object_readout_ctrl_if.sv
// Data-table read port plus record stream handshake of the readout scheduler.
interface object_readout_ctrl_if
    import object_readout_ctrl_pkg::*;
#(
    parameter int LBL_WIDTH = DEF_LBL_WIDTH,
    parameter int LOC_SIZE  = DEF_LOC_SIZE
);

    logic [LBL_WIDTH-1:0] obj_id;
    logic [LOC_SIZE-1:0]  obj_area;
    logic [LOC_SIZE-1:0]  obj_x;
    logic [LOC_SIZE-1:0]  obj_y;

    logic                 rec_valid;
    logic                 rec_ready;
    logic [LBL_WIDTH-1:0] rec_id;
    logic [LOC_SIZE-1:0]  rec_area;
    logic [LOC_SIZE-1:0]  rec_x;
    logic [LOC_SIZE-1:0]  rec_y;

    modport master (
        output obj_id,
        input  obj_area, obj_x, obj_y,
        output rec_valid, rec_id, rec_area, rec_x, rec_y,
        input  rec_ready
    );

    modport slave (
        input  obj_id,
        output obj_area, obj_x, obj_y,
        input  rec_valid, rec_id, rec_area, rec_x, rec_y,
        output rec_ready
    );

endinterface

// File: rtl/object_readout_ctrl.sv
// End-of-frame scheduler: drains the labeler, sweeps the data table and
// streams records whose area meets the runtime threshold.
module object_readout_ctrl
    import object_readout_ctrl_pkg::*;
#(
    parameter int LBL_WIDTH    = DEF_LBL_WIDTH,
    parameter int LOC_SIZE     = DEF_LOC_SIZE,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  frame_end,
    input  logic [LBL_WIDTH-1:0]  num_labels,
    input  logic [LOC_SIZE-1:0]   min_area,
    output logic                  busy,
    output logic [LBL_WIDTH-1:0]  obj_count,
    output logic                  scan_done,
    output logic                  overrun,
    object_readout_ctrl_if.master bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DRAIN   = 3'd1;
    localparam logic [2:0] S_ISSUE   = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_EMIT    = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam drain_cnt_t DRAIN_LOAD = drain_cnt_t'(DRAIN_CYCLES - 1);

    logic [2:0]           state;
    drain_cnt_t           drain_cnt;
    logic [LBL_WIDTH-1:0] last_id;
    logic [LOC_SIZE-1:0]  thr;
    logic [LBL_WIDTH-1:0] obj_id_q;
    logic [LBL_WIDTH-1:0] rec_id_q;
    logic [LOC_SIZE-1:0]  rec_area_q;
    logic [LOC_SIZE-1:0]  rec_x_q;
    logic [LOC_SIZE-1:0]  rec_y_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            drain_cnt  <= '0;
            last_id    <= '0;
            thr        <= '0;
            obj_id_q   <= '0;
            rec_id_q   <= '0;
            rec_area_q <= '0;
            rec_x_q    <= '0;
            rec_y_q    <= '0;
            obj_count  <= '0;
            overrun    <= 1'b0;
        end else begin
            overrun <= frame_end && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (frame_end) begin
                        state     <= S_DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                        obj_count <= '0;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == '0) begin
                        last_id <= num_labels - LBL_WIDTH'(1);
                        thr     <= min_area;
                        if (num_labels <= LBL_WIDTH'(1)) begin
                            state <= S_DONE;
                        end else begin
                            obj_id_q <= LBL_WIDTH'(1);
                            state    <= S_ISSUE;
                        end
                    end else begin
                        drain_cnt <= drain_cnt - drain_cnt_t'(1);
                    end
                end
                S_ISSUE: state <= S_CAPTURE;
                S_CAPTURE: begin
                    // Table data for obj_id arrives one cycle after ISSUE.
                    rec_id_q   <= obj_id_q;
                    rec_area_q <= bus.obj_area;
                    rec_x_q    <= bus.obj_x;
                    rec_y_q    <= bus.obj_y;
                    if (bus.obj_area >= thr) begin
                        state <= S_EMIT;
                    end else if (obj_id_q == last_id) begin
                        state <= S_DONE;
                    end else begin
                        obj_id_q <= obj_id_q + LBL_WIDTH'(1);
                        state    <= S_ISSUE;
                    end
                end
                S_EMIT: begin
                    if (bus.rec_ready) begin
                        obj_count <= obj_count + LBL_WIDTH'(1);
                        if (obj_id_q == last_id) begin
                            state <= S_DONE;
                        end else begin
                            obj_id_q <= obj_id_q + LBL_WIDTH'(1);
                            state    <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    obj_id_q <= '0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy          = (state != S_IDLE);
    assign scan_done     = (state == S_DONE);
    assign bus.rec_valid = (state == S_EMIT);
    assign bus.obj_id    = obj_id_q;
    assign bus.rec_id    = rec_id_q;
    assign bus.rec_area  = rec_area_q;
    assign bus.rec_x     = rec_x_q;
    assign bus.rec_y     = rec_y_q;

endmodule

// File: tb/tb_object_readout_ctrl.sv
// Randomized bench for object_readout_ctrl against a queue-based record model.
module tb_object_readout_ctrl;
    import object_readout_ctrl_pkg::*;

    localparam int LW = DEF_LBL_WIDTH;
    localparam int LS = DEF_LOC_SIZE;
    localparam int D  = DEF_DRAIN_CYCLES;
    localparam int ML = 1 << LW;

    typedef struct { int id; int area; int x; int y; } rec_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          frame_end = 1'b0;
    logic [LW-1:0] num_labels = '0;
    logic [LS-1:0] min_area = '0;
    logic          busy;
    logic [LW-1:0] obj_count;
    logic          scan_done;
    logic          overrun;

    object_readout_ctrl_if #(.LBL_WIDTH(LW), .LOC_SIZE(LS)) bus ();

    object_readout_ctrl #(.LBL_WIDTH(LW), .LOC_SIZE(LS), .DRAIN_CYCLES(D)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_end  (frame_end),
        .num_labels (num_labels),
        .min_area   (min_area),
        .busy       (busy),
        .obj_count  (obj_count),
        .scan_done  (scan_done),
        .overrun    (overrun),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Data table of the labeler: one-cycle read latency.
    logic [LS-1:0] area_mem [ML];
    logic [LS-1:0] x_mem    [ML];
    logic [LS-1:0] y_mem    [ML];
    always @(posedge clk) begin
        bus.obj_area <= area_mem[bus.obj_id];
        bus.obj_x    <= x_mem[bus.obj_id];
        bus.obj_y    <= y_mem[bus.obj_id];
    end

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    rec_t expq[$];
    int   exp_count, exp_lat, exp_last, fe_cyc;
    int   ovr_cnt, stall_total;
    bit   timing_on, done_seen, post_done, scan_active;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_mem;
        for (int i = 0; i < ML; i++) begin
            area_mem[i] = LS'($urandom_range(0, (1 << LS) - 1));
            x_mem[i]    = LS'($urandom);
            y_mem[i]    = LS'($urandom);
        end
    endtask

    // Reference: every allocated label 1..n-1 with area >= thr, in id order.
    task automatic plan_scan(int n, int thr);
        expq.delete();
        exp_count = 0;
        for (int id = 1; id < n; id++) begin
            if (int'(area_mem[id]) >= thr) begin
                expq.push_back('{id, int'(area_mem[id]), int'(x_mem[id]), int'(y_mem[id])});
                exp_count++;
            end
        end
        exp_last = (n > 1) ? n - 1 : 0;
        exp_lat  = D + 1 + 2 * exp_last + exp_count;
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (post_done) begin
                chk("busy_fall", busy, 0);
                post_done = 0;
            end
            if (scan_active && cyc == fe_cyc + 1) chk("busy_rise", busy, 1);
            if (scan_active && exp_last > 0 && cyc == fe_cyc + D + 1)
                chk("first_issue_id", bus.obj_id, 1);
            if (busy) chk("obj_id_bound", bus.obj_id <= exp_last, 1);
            if (overrun) ovr_cnt++;
            if (bus.rec_valid) begin
                if (expq.size() == 0) begin
                    chk("spurious_rec", bus.rec_valid, 0);
                end else begin
                    chk("rec_id",   bus.rec_id,   expq[0].id);
                    chk("rec_area", bus.rec_area, expq[0].area);
                    chk("rec_x",    bus.rec_x,    expq[0].x);
                    chk("rec_y",    bus.rec_y,    expq[0].y);
                    if (bus.rec_ready) void'(expq.pop_front());
                    else stall_total++;
                end
            end
            if (scan_done) begin
                done_seen = 1;
                chk("pending_at_done", expq.size(), 0);
                chk("obj_count", obj_count, exp_count);
                if (timing_on) chk("scan_latency", cyc - fe_cyc, exp_lat);
                post_done   = 1;
                scan_active = 0;
            end
        end
    end

    // mode 0: ready held high; 1: random ready; 2: first record stalled 5 cycles.
    task automatic run_scan(int n, int thr, int mode, bit ovr);
        num_labels = LW'(n);
        min_area   = LS'(thr);
        plan_scan(n, thr);
        if (mode == 2) exp_lat += 5;
        timing_on   = (mode != 1);
        ovr_cnt     = 0;
        stall_total = 0;
        done_seen   = 0;
        bus.rec_ready = (mode == 0);
        fe_cyc      = cyc;
        scan_active = 1;
        frame_end   = 1'b1;
        tick();
        frame_end   = 1'b0;
        for (int k = 0; k < 4000 && !done_seen; k++) begin
            frame_end = ovr && (k == D);
            case (mode)
                0:       bus.rec_ready = 1'b1;
                1:       bus.rec_ready = 1'($urandom_range(0, 1));
                default: bus.rec_ready = (stall_total >= 5);
            endcase
            tick();
        end
        frame_end = 1'b0;
        if (!done_seen) chk("scan_timeout", done_seen, 1);
        repeat (3) tick();
        chk("obj_count_hold", obj_count, exp_count);
        chk("overrun_pulses", ovr_cnt, ovr ? 1 : 0);
    endtask

    initial begin
        bus.rec_ready = 1'b0;
        scan_active = 0;
        post_done = 0;
        exp_last = 0;
        fill_mem();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_rec_valid", bus.rec_valid, 0);
        chk("rst_scan_done", scan_done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_obj_count", obj_count, 0);
        chk("rst_obj_id", bus.obj_id, 0);
        chk("rst_rec_id", bus.rec_id, 0);
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (2) tick();

        // Directed table: ids 1,3,4 pass min_area=16.
        area_mem[1] = 20; area_mem[2] = 3; area_mem[3] = 16; area_mem[4] = 40;
        run_scan(5, 16, 0, 0);
        chk("directed_count", obj_count, 3);

        run_scan(1, $urandom_range(0, 255), 0, 0);
        run_scan(0, 0, 0, 0);

        // Backpressure on the first record.
        fill_mem();
        area_mem[1] = 200;
        run_scan(6, 100, 2, 0);

        // Overrun during the first ISSUE.
        area_mem[1] = 20; area_mem[2] = 3; area_mem[3] = 16; area_mem[4] = 40;
        run_scan(5, 16, 0, 1);

        // Asynchronous reset while a record is pending.
        fill_mem();
        for (int i = 1; i < 5; i++) area_mem[i] = 8'd100;
        num_labels = 5;
        min_area   = 0;
        plan_scan(5, 0);
        timing_on = 0;
        bus.rec_ready = 1'b0;
        fe_cyc = cyc;
        scan_active = 1;
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        for (int k = 0; k < 50 && !bus.rec_valid; k++) tick();
        chk("emit_reached", bus.rec_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_rec_valid", bus.rec_valid, 0);
        chk("arst_scan_done", scan_done, 0);
        chk("arst_overrun", overrun, 0);
        chk("arst_obj_count", obj_count, 0);
        chk("arst_obj_id", bus.obj_id, 0);
        chk("arst_rec_id", bus.rec_id, 0);
        chk("arst_rec_area", bus.rec_area, 0);
        chk("arst_rec_x", bus.rec_x, 0);
        chk("arst_rec_y", bus.rec_y, 0);
        expq.delete();
        scan_active = 0;
        bus.rec_ready = 1'b1;
        repeat (2) tick();
        reset_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("idle_after_reset", busy, 0);
            chk("no_rec_after_reset", bus.rec_valid, 0);
        end

        // Full label range with zero threshold.
        fill_mem();
        run_scan(ML - 1, 0, 0, 0);
        chk("full_range_count", obj_count, ML - 2);
        run_scan(ML - 1, 0, 1, 0);

        for (int t = 0; t < 25; t++) begin
            fill_mem();
            run_scan($urandom_range(0, ML - 1), $urandom_range(0, 255),
                     $urandom_range(0, 1), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/object_readout_ctrl.md
# object_readout_ctrl

End-of-frame scheduler for the connected-components labeler's data table. After the last pixel of a frame, it waits for the labeling pipeline to drain. It then sweeps `obj_id` over every allocated label, filters out objects below a runtime minimum area, and streams the surviving object records (id, area, x-sum, y-sum) to downstream logic over a valid/ready handshake. While it runs, it asserts `busy` to hold off the pixel source.

## Interface
Parameters:
- LBL_WIDTH, default `` `LBL_WIDTH ``: label/object-id width.
- LOC_SIZE, default `` `LOC_SIZE ``: width of area and coordinate accumulators.
- DRAIN_CYCLES, default 4: clocks from `frame_end` until the data table is final (range 1..15).

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- frame_end  in  1  one-cycle pulse marking the last pixel of a frame accepted by the labeler.
- num_labels  in  LBL_WIDTH  next-free label from the labeler (labels 1..num_labels-1 are allocated).
- min_area  in  LOC_SIZE  runtime filter threshold, sampled at end of DRAIN.
- obj_id  out  LBL_WIDTH  data-table read address to the labeler.
- obj_area, obj_x, obj_y  in  LOC_SIZE each  data-table read data, valid 1 cycle after `obj_id`.
- busy  out  1  high from the cycle after an accepted `frame_end` through DONE; upstream must not send pixels while high.
- rec_valid  out  1  record available.
- rec_ready  in  1  downstream accepts.
- rec_id  out  LBL_WIDTH  label of the record.
- rec_area, rec_x, rec_y  out  LOC_SIZE each  record payload.
- obj_count  out  LBL_WIDTH  records emitted in the current/last scan.
- scan_done  out  1  one-cycle pulse when the scan completes.
- overrun  out  1  one-cycle pulse when `frame_end` arrives while `busy`.

## Operation
- States: IDLE, DRAIN, ISSUE, CAPTURE, EMIT, DONE.
- IDLE: `obj_id`=0; `frame_end` -> DRAIN, load drain counter with DRAIN_CYCLES-1, clear `obj_count`.
- DRAIN: counter decrements each cycle. At 0:
  - latch `last_id` = `num_labels`-1 and `thr` = `min_area`.
  - If `num_labels` <= 1 -> DONE; otherwise `obj_id`=1 -> ISSUE.
- ISSUE: `obj_id` is driven; -> CAPTURE.
- CAPTURE: register `obj_area/x/y` and `obj_id` into the rec_* registers.
  - If `obj_area` >= `thr` -> EMIT.
  - Else if `obj_id` == `last_id` -> DONE.
  - Else increment `obj_id` -> ISSUE.
- EMIT: `rec_valid`=1. On `rec_valid & rec_ready`, increment `obj_count`, then go to DONE if `obj_id` == `last_id`, else increment `obj_id` -> ISSUE.
- DONE: `scan_done`=1 for one cycle -> IDLE.
- `busy` = (state != IDLE).
- `frame_end` outside IDLE is ignored (state unaffected) and pulses `overrun`.
- `obj_id` never wraps. `last_id` is at most 2^LBL_WIDTH-2 because the labeler saturates `num_labels` at `MAX_LABEL`-1.
- Comparison `obj_area` >= `thr` is unsigned. With `thr`=0, every allocated label is emitted.

## Timing
- Reset values: state IDLE; `obj_id`, rec_*, `obj_count` = 0; `rec_valid`, `busy`, `scan_done`, `overrun` = 0.
- Asynchronous reset mid-scan aborts immediately. No record is emitted after reset deassertion until a new `frame_end`.
- `busy` rises in the cycle after `frame_end`. The first ISSUE occurs DRAIN_CYCLES+1 cycles after `frame_end`.
- Per label: 2 cycles if filtered; 2 + wait cycles if emitted. Minimum 3 cycles per emitted record with `rec_ready` held high.
- Handshake: once `rec_valid` rises, it and all rec_* payload stay stable until accepted. `rec_valid` never drops without acceptance. `rec_ready` may toggle freely.
- `scan_done` pulses in the cycle after the final EMIT acceptance or final CAPTURE. `busy` drops in the following cycle.
- `obj_count` is stable from `scan_done` until the next accepted `frame_end`.

## Structure
- `LBL_WIDTH`, `LOC_SIZE` and `MAX_LABEL` come from global.vh. Add `` `DRAIN_CYCLES `` there as the shared default.
- State encoding is a local 3-bit localparam set, not shared.
- Single module with no sub-modules. The drain counter and record register are inline.

## Test plan
- `num_labels`=5, areas {1:20, 2:3, 3:16, 4:40}, `min_area`=16, `rec_ready`=1 -> records for ids 1, 3, 4 in order; `obj_count`=3; `scan_done` 1 cycle after id 4 is accepted.
- `num_labels`=1, `frame_end` -> DONE directly after DRAIN_CYCLES; no `rec_valid`; `obj_count`=0.
- Backpressure: `rec_ready` low for 5 cycles during record id 1 -> `rec_valid` and payload held constant for all 5 cycles; exactly one transfer.
- `frame_end` pulsed during ISSUE -> `overrun` pulses once; scan result is unchanged.
- `reset_n` asserted during EMIT -> all outputs return to 0 asynchronously; after release, nothing happens until `frame_end`.
- `min_area`=0, `num_labels`=`MAX_LABEL`-1 -> every id 1..`MAX_LABEL`-2 is emitted; `obj_id` never reaches 0 or wraps.
